// File: rtl/mips_result_serializer.sv
// Captures MIPS core result bundles into a FIFO and streams each one out as a
// header word followed by four result words (header only for failed instructions).
module mips_result_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       res_valid,
    input  logic                       res_fail,
    input  logic [31:0]                res_1,
    input  logic [31:0]                res_2,
    input  logic [31:0]                res_3,
    input  logic [31:0]                res_4,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [31:0]                out_data,
    output logic                       out_last,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_HDR,
        S_D1,
        S_D2,
        S_D3,
        S_D4
    } state_t;

    state_t state, state_nxt;

    logic              mem_fail [DEPTH];
    logic [15:0]       mem_seq  [DEPTH];
    logic [3:0][31:0]  mem_data [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   seq;

    logic head_fail;
    logic handshake;
    logic last_word;
    logic pop;
    logic room;
    logic push;

    // Output handshake: a word moves on a rising edge where out_valid and
    // out_ready are both 1; out_data/out_last depend only on state and the
    // head bundle, so they hold while the consumer stalls.
    assign head_fail = mem_fail[rd_ptr];
    assign handshake = (state != S_EMPTY) && out_ready;
    assign last_word = ((state == S_HDR) && head_fail) || (state == S_D4);
    assign pop       = handshake && last_word;
    // A full FIFO still accepts a bundle in the cycle its head leaves.
    assign room      = (fifo_count < CW'(DEPTH)) || pop;
    assign push      = res_valid && room;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_fail[wr_ptr] <= res_fail;
            mem_seq[wr_ptr]  <= seq;
            mem_data[wr_ptr] <= {res_4, res_3, res_2, res_1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (res_valid) begin
                seq <= seq + 1'b1;
                if (!room) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_data  = 32'h0;
        out_last  = 1'b0;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = {head_fail, 15'b0, mem_seq[rd_ptr]};
                out_last  = head_fail;
            end
            S_D1: begin
                out_valid = 1'b1;
                out_data  = mem_data[rd_ptr][0];
            end
            S_D2: begin
                out_valid = 1'b1;
                out_data  = mem_data[rd_ptr][1];
            end
            S_D3: begin
                out_valid = 1'b1;
                out_data  = mem_data[rd_ptr][2];
            end
            S_D4: begin
                out_valid = 1'b1;
                out_data  = mem_data[rd_ptr][3];
                out_last  = 1'b1;
            end
            default: state_nxt = S_EMPTY;
        endcase

        if (handshake) begin
            if (last_word) begin
                // Another bundle remains if one was queued behind the head or arrives now.
                state_nxt = ((fifo_count > CW'(1)) || push) ? S_HDR : S_EMPTY;
            end else begin
                case (state)
                    S_HDR:   state_nxt = S_D1;
                    S_D1:    state_nxt = S_D2;
                    S_D2:    state_nxt = S_D3;
                    S_D3:    state_nxt = S_D4;
                    default: state_nxt = S_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_result_serializer.sv
// Bench for mips_result_serializer: a bundle-queue reference model checked every
// cycle, plus directed scenarios with hand-computed word streams.
module tb_mips_result_serializer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          res_valid;
    logic          res_fail;
    logic [31:0]   res_1, res_2, res_3, res_4;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_last;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    mips_result_serializer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (res_valid),
        .res_fail   (res_fail),
        .res_1      (res_1),
        .res_2      (res_2),
        .res_3      (res_3),
        .res_4      (res_4),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic             fail;
        logic [15:0]      seq;
        logic [3:0][31:0] w;
    } bundle_t;

    bundle_t     exp_q[$];
    int          m_idx;
    logic [15:0] m_seq;
    logic        m_ovf;
    logic [32:0] obs_q[$];
    int          n_tests;
    int          n_fail;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_idx   = 0;
        m_seq   = 16'h0;
        m_ovf   = 1'b0;
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {out_last, out_data} the head bundle must present at word position m_idx
    function automatic logic [32:0] model_word();
        bundle_t b;
        b = exp_q[0];
        if (m_idx == 0) begin
            return {b.fail, b.fail, 15'b0, b.seq};
        end
        return {(m_idx == 4), b.w[m_idx-1]};
    endfunction

    always @(negedge rst_n) begin
        exp_q.delete();
        m_idx = 0;
        m_seq = 16'h0;
        m_ovf = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit      hs;
            bit      lst;
            bit      rm;
            bundle_t nb;
            hs  = (exp_q.size() > 0) && out_ready;
            lst = hs && (exp_q[0].fail || (m_idx == 4));
            rm  = (exp_q.size() < DEPTH) || lst;
            if (hs) begin
                if (lst) begin
                    void'(exp_q.pop_front());
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (res_valid) begin
                if (rm) begin
                    nb.fail = res_fail;
                    nb.seq  = m_seq;
                    nb.w    = {res_4, res_3, res_2, res_1};
                    exp_q.push_back(nb);
                end else begin
                    m_ovf = 1'b1;
                end
                m_seq = m_seq + 16'd1;
            end
        end
    end

    // ---------------- per-cycle compare + word monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 33'(out_valid), 33'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("word", {out_last, out_data}, model_word());
            end else begin
                check("idle_word", {out_last, out_data}, 33'h0);
            end
            check("fifo_count", 33'(fifo_count), 33'(exp_q.size()));
            check("overflow", 33'(overflow), 33'(m_ovf));
            if (out_valid && out_ready) begin
                obs_q.push_back({out_last, out_data});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bundle(input logic f, input logic [31:0] w1, input logic [31:0] w2,
                                input logic [31:0] w3, input logic [31:0] w4);
        res_valid = 1'b1;
        res_fail  = f;
        res_1     = w1;
        res_2     = w2;
        res_3     = w3;
        res_4     = w4;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic drive_random_ok();
        drive_bundle(1'b0, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic do_reset();
        res_valid = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        obs_q.delete();
        tick();
    endtask

    task automatic wait_words(input int n, input string name);
        int b;
        b = 0;
        while (obs_q.size() < n && b < 200) begin
            tick();
            b++;
        end
        check({name, "_timeout"}, 33'(obs_q.size() >= n), 33'h1);
    endtask

    function automatic logic [32:0] obs_at(input int i);
        if (i < obs_q.size()) begin
            return obs_q[i];
        end
        return 33'h1_FFFF_FFFF;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [32:0] exp_single [5];
        logic [32:0] exp_bp [5];
        exp_single = '{{1'b0, 32'h0}, {1'b0, 32'd10}, {1'b0, 32'd20}, {1'b0, 32'd30}, {1'b1, 32'd40}};
        exp_bp     = '{{1'b0, 32'h2}, {1'b0, 32'd1}, {1'b0, 32'd2}, {1'b0, 32'd3}, {1'b1, 32'd4}};

        res_valid = 1'b0;
        res_fail  = 1'b0;
        res_1     = '0;
        res_2     = '0;
        res_3     = '0;
        res_4     = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 33'(out_valid), 33'h0);
        check("rst_out_data", 33'(out_data), 33'h0);
        check("rst_out_last", 33'(out_last), 33'h0);
        check("rst_overflow", 33'(overflow), 33'h0);
        check("rst_fifo_count", 33'(fifo_count), 33'h0);
        rst_n = 1'b1;
        tick();

        // single bundle
        out_ready = 1'b1;
        obs_q.delete();
        drive_bundle(1'b0, 32'd10, 32'd20, 32'd30, 32'd40);
        wait_words(5, "single");
        for (int i = 0; i < 5; i++) begin
            check("single_word", obs_at(i), exp_single[i]);
        end
        tick();
        check("single_count", 33'(fifo_count), 33'h0);

        // failed bundle: header only, seq 1
        obs_q.delete();
        drive_bundle(1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        wait_words(1, "failed");
        check("failed_word", obs_at(0), {1'b1, 32'h8000_0001});
        tick();

        // backpressure: header held for 6 cycles
        out_ready = 1'b0;
        obs_q.delete();
        drive_bundle(1'b0, 32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < 6; i++) begin
            check("bp_hold", {out_valid, out_last, out_data}, {1'b1, 1'b0, 32'h2});
            tick();
        end
        out_ready = 1'b1;
        wait_words(5, "bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_word", obs_at(i), exp_bp[i]);
        end
        tick();

        // overflow: six bundles into a 4-deep FIFO
        do_reset();
        repeat (6) drive_random_ok();
        check("ovf_count", 33'(fifo_count), 33'd4);
        check("ovf_flag", 33'(overflow), 33'h1);
        out_ready = 1'b1;
        wait_words(20, "ovf_drain");
        for (int i = 0; i < 4; i++) begin
            check("ovf_hdr_seq", obs_at(i * 5), {1'b0, 32'(i)});
        end
        obs_q.delete();
        drive_random_ok();
        wait_words(1, "ovf_next");
        check("ovf_next_seq", obs_at(0), {1'b0, 32'd6});
        repeat (8) tick();

        // full FIFO: push lands on the cycle the head's last word leaves
        do_reset();
        repeat (4) drive_random_ok();
        check("full_count", 33'(fifo_count), 33'd4);
        out_ready = 1'b1;
        repeat (4) tick();
        drive_random_ok();
        check("full_pop_count", 33'(fifo_count), 33'd4);
        check("full_pop_ovf", 33'(overflow), 33'h0);
        repeat (25) tick();

        // asynchronous reset during D2
        do_reset();
        drive_bundle(1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("mid_d2_word", {out_valid, out_last, out_data}, {1'b1, 1'b0, 32'h22});
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 33'(out_valid), 33'h0);
        check("mid_rst_data", 33'(out_data), 33'h0);
        check("mid_rst_last", 33'(out_last), 33'h0);
        check("mid_rst_count", 33'(fifo_count), 33'h0);
        check("mid_rst_ovf", 33'(overflow), 33'h0);
        #1;
        rst_n = 1'b1;
        tick();
        obs_q.delete();
        out_ready = 1'b1;
        drive_random_ok();
        wait_words(1, "mid_rst_next");
        check("mid_rst_seq", obs_at(0), {1'b0, 32'h0});
        repeat (8) tick();

        // randomized traffic: light then heavy backpressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            res_valid = ($urandom_range(0, 99) < 40);
            res_fail  = ($urandom_range(0, 3) == 0);
            res_1     = $urandom;
            res_2     = $urandom;
            res_3     = $urandom;
            res_4     = $urandom;
            out_ready = ($urandom_range(0, 99) < ((i < 1500) ? 90 : 30));
            tick();
        end
        res_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();
        check("final_drained", 33'(fifo_count), 33'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
